// File: rtl/micro_uart_pkg.sv
// rtl/micro_uart_pkg.sv - shared register map, bit positions and RX state encodings
package micro_uart_pkg;

  localparam logic [3:0] OFF_DATA = 4'h0;
  localparam logic [3:0] OFF_BAUD = 4'h4;
  localparam logic [3:0] OFF_STAT = 4'h8;

  localparam int ST_RX_HAS_DATA = 0;
  localparam int ST_RX_OVERFLOW = 1;
  localparam int ST_TX_READY    = 2;
  localparam int ST_RX_IRQ      = 3;
  localparam int ST_TX_IRQ      = 4;

  localparam int CTL_RX_EN = 0;
  localparam int CTL_TX_EN = 1;

  localparam int TICKS_PER_BIT = 8;
  localparam logic [2:0] BIT_LAST_TICK  = 3'(TICKS_PER_BIT - 1);
  localparam logic [2:0] HALF_LAST_TICK = 3'(TICKS_PER_BIT / 2 - 1);
  localparam logic [3:0] TX_STOP_BIT    = 4'd9;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_LOAD = 2'd2,
    RX_STOP = 2'd3
  } rx_state_e;

endpackage

// File: rtl/micro_uart_core.sv
// rtl/micro_uart_core.sv - baud generator, 8N1 transmitter, receiver and RX holding flags
module micro_uart_core
  import micro_uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] baud_i,
  input  logic        tx_start_i,
  input  logic [7:0]  tx_data_i,
  input  logic        rx_read_i,
  input  logic        ser_in_i,
  output logic        ser_out_o,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_has_data_o,
  output logic        rx_overflow_o
);

  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic        tick;

  assign tick       = (baud_cnt_q == 16'd0);
  assign baud_cnt_d = tick ? baud_i : baud_cnt_q - 16'd1;

  always_ff @(posedge clk) begin
    if (reset) baud_cnt_q <= 16'd0;
    else       baud_cnt_q <= baud_cnt_d;
  end

  logic       tx_busy_q;
  logic       ser_out_q;
  logic [8:0] tx_shift_q;
  logic [3:0] tx_bit_q;
  logic [2:0] tx_tick_q;

  // The start bit is driven as soon as the write lands; later bits change on tick boundaries.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy_q  <= 1'b0;
      ser_out_q  <= 1'b1;
      tx_shift_q <= '1;
      tx_bit_q   <= 4'd0;
      tx_tick_q  <= 3'd0;
    end else if (!tx_busy_q) begin
      if (tx_start_i) begin
        tx_busy_q  <= 1'b1;
        ser_out_q  <= 1'b0;
        tx_shift_q <= {1'b1, tx_data_i};
        tx_bit_q   <= 4'd0;
        tx_tick_q  <= 3'd0;
      end
    end else if (tick) begin
      tx_tick_q <= tx_tick_q + 3'd1;
      if (tx_tick_q == BIT_LAST_TICK) begin
        if (tx_bit_q == TX_STOP_BIT) begin
          tx_busy_q <= 1'b0;
          ser_out_q <= 1'b1;
        end else begin
          ser_out_q  <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
          tx_bit_q   <= tx_bit_q + 4'd1;
        end
      end
    end
  end

  rx_state_e  rx_state;
  logic       rx_in_q;
  logic       rx_start_q;
  logic [2:0] rx_tick_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_shift_q;
  logic       rx_xfer;

  assign rx_xfer = (rx_state == RX_LOAD) && tick && (rx_tick_q == BIT_LAST_TICK);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_in_q    <= 1'b1;
      rx_start_q <= 1'b0;
      rx_tick_q  <= 3'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
    end else begin
      rx_in_q <= ser_in_i;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_in_q) begin
            rx_state   <= RX_DATA;
            rx_start_q <= 1'b1;
            rx_tick_q  <= 3'd0;
            rx_bit_q   <= 3'd0;
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 3'd1;
            if (rx_start_q) begin
              // Half a bit in: a high line means the start edge was a glitch.
              if (rx_tick_q == HALF_LAST_TICK) begin
                rx_tick_q  <= 3'd0;
                rx_start_q <= 1'b0;
                if (rx_in_q) rx_state <= RX_IDLE;
              end
            end else if (rx_tick_q == BIT_LAST_TICK) begin
              rx_shift_q <= {rx_in_q, rx_shift_q[7:1]};
              rx_bit_q   <= rx_bit_q + 3'd1;
              if (rx_bit_q == 3'd7) rx_state <= RX_LOAD;
            end
          end
        end
        RX_LOAD: begin
          if (tick) begin
            rx_tick_q <= rx_tick_q + 3'd1;
            if (rx_tick_q == BIT_LAST_TICK) rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_in_q) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  logic [7:0] rx_data_q;
  logic       rx_has_q;
  logic       rx_ovf_q;

  // A read landing on the transfer clock consumes the old byte, so no overflow is flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_q <= 8'h00;
      rx_has_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
    end else if (rx_xfer) begin
      rx_data_q <= rx_shift_q;
      rx_has_q  <= 1'b1;
      rx_ovf_q  <= rx_has_q & ~rx_read_i;
    end else if (rx_read_i) begin
      rx_has_q <= 1'b0;
      rx_ovf_q <= 1'b0;
    end
  end

  assign ser_out_o     = ser_out_q;
  assign tx_ready_o    = ~tx_busy_q;
  assign rx_data_o     = rx_data_q;
  assign rx_has_data_o = rx_has_q;
  assign rx_overflow_o = rx_ovf_q;

endmodule

// File: rtl/micro_uart_apb.sv
// rtl/micro_uart_apb.sv - APB register wrapper and interrupt for the 8N1 UART core
module micro_uart_apb
  import micro_uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        apb_psel,
  input  logic        apb_penable,
  input  logic        apb_pwrite,
  input  logic [3:0]  apb_paddr,
  input  logic [31:0] apb_pwdata,
  output logic [31:0] apb_prdata,
  output logic        irq,
  input  logic        ser_in,
  output logic        ser_out
);

  logic        wr_en, rd_en;
  logic [3:0]  reg_off;
  logic [15:0] baud_q;
  logic        rx_en_q, tx_en_q, irq_q;
  logic        tx_ready, rx_has_data, rx_overflow;
  logic [7:0]  rx_data;
  logic [4:0]  status;
  logic        unused_bits;

  assign wr_en       = apb_psel & apb_penable & apb_pwrite;
  assign rd_en       = apb_psel & apb_penable & ~apb_pwrite;
  assign reg_off     = {apb_paddr[3:2], 2'b00};
  assign unused_bits = ^{apb_pwdata[31:16], apb_paddr[1:0]};

  always_comb begin
    status                 = '0;
    status[ST_RX_HAS_DATA] = rx_has_data;
    status[ST_RX_OVERFLOW] = rx_overflow;
    status[ST_TX_READY]    = tx_ready;
    status[ST_RX_IRQ]      = rx_en_q & rx_has_data;
    status[ST_TX_IRQ]      = tx_en_q & tx_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q  <= 16'd0;
      rx_en_q <= 1'b0;
      tx_en_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_en && reg_off == OFF_BAUD) baud_q <= apb_pwdata[15:0];
      if (wr_en && reg_off == OFF_STAT) begin
        rx_en_q <= apb_pwdata[CTL_RX_EN];
        tx_en_q <= apb_pwdata[CTL_TX_EN];
      end
      irq_q <= status[ST_RX_IRQ] | status[ST_TX_IRQ];
    end
  end

  always_comb begin
    apb_prdata = 32'h0;
    if (apb_psel) begin
      case (reg_off)
        OFF_DATA: apb_prdata[7:0]  = rx_data;
        OFF_BAUD: apb_prdata[15:0] = baud_q;
        OFF_STAT: apb_prdata[4:0]  = status;
        default:  apb_prdata       = 32'h0;
      endcase
    end
  end

  micro_uart_core u_core (
    .clk           (clk),
    .reset         (reset),
    .baud_i        (baud_q),
    .tx_start_i    (wr_en && reg_off == OFF_DATA),
    .tx_data_i     (apb_pwdata[7:0]),
    .rx_read_i     (rd_en && reg_off == OFF_DATA),
    .ser_in_i      (ser_in),
    .ser_out_o     (ser_out),
    .tx_ready_o    (tx_ready),
    .rx_data_o     (rx_data),
    .rx_has_data_o (rx_has_data),
    .rx_overflow_o (rx_overflow)
  );

  assign irq = irq_q;

endmodule

// File: tb/tb_micro_uart_apb.sv
// tb/tb_micro_uart_apb.sv - directed loopback bench for micro_uart_apb
module tb_micro_uart_apb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0]  paddr = 4'h0;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        irq, ser_out, ser_in;
  logic        force_low = 1'b0;
  logic [31:0] rd;
  logic        ok;
  int          checks = 0;
  int          errors = 0;
  int          cal;

  assign ser_in = force_low ? 1'b0 : ser_out;

  always #5 clk = ~clk;

  micro_uart_apb dut (
    .clk         (clk),
    .reset       (reset),
    .apb_psel    (psel),
    .apb_penable (penable),
    .apb_pwrite  (pwrite),
    .apb_paddr   (paddr),
    .apb_pwdata  (pwdata),
    .apb_prdata  (prdata),
    .irq         (irq),
    .ser_in      (ser_in),
    .ser_out     (ser_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end at a falling edge; the access takes effect on the second rising edge.
  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk); penable = 1'b1; #1; d = prdata;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_status(input int bitn, input int max_polls, output logic found);
    logic [31:0] s;
    found = 1'b0;
    for (int i = 0; i < max_polls && !found; i++) begin
      apb_read(4'h8, s);
      if (s[bitn]) found = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic f;
    wait_status(2, 400, f);
    chk("tx_ready_wait", 32'(f), 32'd1);
    apb_write(4'h0, {24'h0, b});
  endtask

  task automatic pair_setup();
    do_reset();
    apb_write(4'h4, 32'd3);
    apb_write(4'h0, 32'h81);
    repeat (330) @(negedge clk);
    apb_write(4'h0, 32'h7E);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lb_bytes [5];
    lb_bytes = '{8'h81, 8'h7E, 8'hFF, 8'h00, 8'hC3};

    @(negedge clk);
    do_reset();
    chk("rst_ser_out", 32'(ser_out), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_prdata_idle", prdata, 32'h0);
    apb_read(4'h8, rd); chk("rst_status", rd, 32'h04);
    apb_read(4'h4, rd); chk("rst_baud", rd, 32'h0);
    apb_read(4'h0, rd); chk("rst_data", rd, 32'h0);

    apb_write(4'h4, 32'hFFFF0003);
    apb_read(4'h4, rd); chk("baud_rw", rd, 32'h3);

    foreach (lb_bytes[i]) begin
      send(lb_bytes[i]);
      wait_status(0, 240, ok);
      chk("lb_rx_wait", 32'(ok), 32'd1);
      apb_read(4'h0, rd); chk("lb_data", rd, {24'h0, lb_bytes[i]});
    end

    send(8'h81);
    send(8'h7E);
    wait_status(2, 400, ok); chk("ovf_tx_done", 32'(ok), 32'd1);
    apb_read(4'h8, rd); chk("ovf_flags_set", 32'(rd[1:0]), 32'h3);
    apb_read(4'h0, rd); chk("ovf_data_newest", rd, 32'h7E);
    apb_read(4'h8, rd); chk("ovf_flags_clear", 32'(rd[1:0]), 32'h0);

    pair_setup();
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 4'h8;
    cal = 0;
    for (int i = 1; i <= 600 && cal == 0; i++) begin
      @(negedge clk); #1;
      if (prdata[1]) cal = i;
    end
    psel = 1'b0;
    chk("coin_calibrate", 32'(cal != 0), 32'd1);
    pair_setup();
    repeat (cal - 2) @(negedge clk);
    apb_read(4'h0, rd); chk("coin_old_byte", rd, 32'h81);
    apb_read(4'h8, rd); chk("coin_flags", 32'(rd[1:0]), 32'h1);
    apb_read(4'h0, rd); chk("coin_new_byte", rd, 32'h7E);

    repeat (40) @(negedge clk);
    force_low = 1'b1;
    repeat (288) @(negedge clk);
    wait_status(0, 32, ok); chk("stuck_rx_wait", 32'(ok), 32'd1);
    apb_read(4'h8, rd); chk("stuck_flags", 32'(rd[1:0]), 32'h1);
    repeat (480) @(negedge clk);
    apb_read(4'h8, rd); chk("stuck_single_byte", 32'(rd[1:0]), 32'h1);
    force_low = 1'b0;
    repeat (8) @(negedge clk);
    apb_read(4'h0, rd); chk("stuck_data", rd, 32'h00);
    apb_read(4'h8, rd); chk("stuck_cleared", 32'(rd[0]), 32'h0);

    wait_status(2, 400, ok); chk("irq_tx_idle", 32'(ok), 32'd1);
    apb_write(4'h8, 32'h3);
    apb_read(4'h8, rd); chk("irq_tx_pend", 32'(rd[4]), 32'd1);
    chk("irq_high", 32'(irq), 32'd1);
    apb_read(4'h8, rd); chk("ctrl_not_readable", 32'(rd[31:5]), 32'd0);
    apb_write(4'h0, 32'hAA);
    apb_read(4'h8, rd); chk("irq_tx_busy", 32'(rd[4]), 32'd0);
    chk("irq_low", 32'(irq), 32'd0);
    wait_status(3, 240, ok); chk("irq_rx_pend", 32'(ok), 32'd1);
    apb_read(4'h0, rd); chk("irq_rx_data", rd, 32'hAA);
    apb_read(4'h8, rd); chk("irq_rx_clear", 32'(rd[3]), 32'd0);

    send(8'h55);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_ser_out", 32'(ser_out), 32'd1);
    chk("midreset_irq", 32'(irq), 32'd0);
    apb_read(4'h8, rd); chk("midreset_status", rd, 32'h04);
    chk("midreset_irq_later", 32'(irq), 32'd0);
    repeat (400) @(negedge clk);
    apb_read(4'h8, rd); chk("midreset_rx_aborted", rd, 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/micro_uart_apb.md
# micro_uart_apb

Minimal 8N1 UART with an APB slave register interface and a single interrupt output. It sits on the peripheral APB bus and gives software one transmit holding register, one receive holding register, a programmable baud divisor and a status/control register. There is no FIFO, and the receiver has a single-byte buffer with overflow detection.

## Interface
- No parameters.
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- apb_psel  in  1  slave select
- apb_penable  in  1  APB access phase
- apb_pwrite  in  1  1 = write, 0 = read
- apb_paddr  in  4  byte address; bits [1:0] ignored
- apb_pwdata  in  32  write data; only [15:0] used
- apb_prdata  out  32  read data; unused bits read 0
- irq  out  1  level interrupt, active high
- ser_in  in  1  serial receive line, idle high
- ser_out  out  1  serial transmit line, idle high

## Operation
- **Register map:**
  - 0x0 DATA. A write loads the TX byte from pwdata[7:0]. A read returns the RX byte in [7:0].
  - 0x4 BAUD. 16-bit divisor, read/write.
  - 0x8 STATUS (read) / CONTROL (write).
- **STATUS bits:**
  - [0] rx_has_data
  - [1] rx_overflow
  - [2] tx_ready (transmitter idle)
  - [3] rx_irq_pend = rx_en & rx_has_data
  - [4] tx_irq_pend = tx_en & tx_ready
- **CONTROL bits:** [0] rx_en, [1] tx_en. Control is write-only; it is not readable at 0x8.
- irq = rx_irq_pend | tx_irq_pend.
- **Bus accesses:**
  - A write takes effect on the clock where psel & penable & pwrite.
  - apb_prdata is combinational from paddr while psel = 1, and 0 otherwise.
  - Read side effects happen on the clock where psel & penable & !pwrite.
- **Baud tick:** a 16-bit down-counter reloads from BAUD and emits a one-clock tick when it reaches 0, giving a period of BAUD+1 clocks. One bit time is 8 ticks.
- **Transmitter:**
  - A DATA write while tx_ready = 1 starts a frame: start bit 0, 8 data bits LSB first, stop bit 1, each lasting 8 ticks.
  - tx_ready drops on the clock after the write and returns once the stop bit completes.
  - A DATA write while tx_ready = 0 is ignored.
- **Receiver state machine** (2-bit state: IDLE=0, DATA=1, LOAD=2, STOP=3):
  - IDLE: a low on ser_in moves to DATA. Mid-start check: after 4 ticks, if the line is high, return to IDLE.
  - DATA: samples 8 bits at bit centres (every 8 ticks), LSB first.
  - LOAD: at the stop-bit centre, transfers the shift register to the holding register and sets rx_has_data. The stop-bit value is not checked, so a missing stop bit still delivers the byte. Then moves to STOP.
  - STOP: waits until ser_in is high, then returns to IDLE. A line stuck low therefore yields exactly one byte.
- **Overflow:** a transfer while rx_has_data = 1 sets rx_overflow and overwrites the holding register with the new byte.
- **DATA read:** clears rx_has_data and rx_overflow.
- **Read coinciding with a transfer** (same clock): the read returns the old byte, the new byte is stored, rx_has_data stays 1, and no overflow is flagged.

## Timing
- **Reset values:** BAUD = 0, CONTROL = 0, rx_has_data = 0, rx_overflow = 0, holding register 0x00, TX idle (tx_ready = 1), RX in IDLE, ser_out = 1, irq = 0, apb_prdata = 0.
- Reset mid-frame aborts both the TX and RX frames immediately; ser_out returns high on the next clock.
- Status reflects a write one clock after the access phase. irq is registered from the status flags and settles one clock later than the flags.
- A BAUD write takes effect at the next counter reload.
- Frame length is 80 ticks = 80·(BAUD+1) clocks. Loopback latency from DATA write to rx_has_data is at most 80·(BAUD+1)+4 clocks.

## Structure
- Shared package holds: register offsets (DATA 0x0, BAUD 0x4, STAT 0x8), status and control bit positions, RX state encodings, and the ticks-per-bit constant (8).
- One sub-module, micro_uart_core, contains the baud generator, TX, RX, the holding register and flags. The top level is the APB decode/register wrapper; the RX state register in the core is named rx_state.

## Test plan
All scenarios use ser_in tied to ser_out and BAUD = 3.
- **Loopback:** send 0x81, 0x7E, 0xFF, 0x00, 0xC3. For each, poll STATUS bit0 until set (within 240 polls), then read DATA -> the same byte.
- **Overflow:** send 0x81 then 0x7E without reading, then wait for tx_ready.
  - STATUS -> bits 0 and 1 set.
  - Read DATA, then STATUS -> bits 0 and 1 clear.
- **Coincident read:** send 0x81 and 0x7E, and issue a DATA read so its access phase hits the LOAD transfer clock of the second byte -> read returns 0x81, next read returns 0x7E, no overflow.
- **Stuck low:** hold ser_in = 0 for 288 clocks, then STATUS -> bit0 = 1, bit1 = 0. Hold a further 480 clocks -> still bit0 = 1, bit1 = 0. Release the line, read DATA -> 0x00.
- **Interrupts:**
  - CONTROL = 0x3 with TX idle -> STATUS bit4 = 1, irq = 1.
  - Write DATA 0xAA -> bit4 = 0, irq = 0.
  - On receive -> bit3 = 1.
  - Read DATA -> 0xAA, and bit3 clears.
- **Reset:** assert reset mid-transmit -> ser_out = 1, STATUS = 0x04, irq = 0 on the following clock.
